// File: rtl/mux_scan_seq.sv
// Scan sequencer for a 4:1 mux: steps sel through 0..3 with a programmable dwell,
// captures the mux output per slot and presents complete 4-slot frames.
module mux_scan_seq #(
    parameter int unsigned width  = 4,
    parameter int unsigned swidth = 2,
    parameter int unsigned dwidth = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 continuous,
    input  logic [dwidth-1:0]    dwell,
    input  logic [width-1:0]     mux_o,
    output logic [swidth-1:0]    sel,
    output logic                 busy,
    output logic                 cap_valid,
    output logic [swidth-1:0]    cap_idx,
    output logic [width-1:0]     cap_data,
    output logic [4*width-1:0]   frame_data,
    output logic                 frame_valid,
    output logic                 done
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e              state_q, state_d;
    logic [dwidth-1:0]   dwell_q, count_q;
    logic                cont_q, stop_q;
    logic [swidth-1:0]   sel_q, cap_idx_q;
    logic [width-1:0]    cap_data_q;
    logic [width-1:0]    shadow_q [3];
    logic [4*width-1:0]  frame_data_q;
    logic                busy_q, cap_valid_q, frame_valid_q, done_q;

    logic start_scan, capture, frame_end, finish;

    always_comb begin
        state_d    = state_q;
        start_scan = 1'b0;
        capture    = 1'b0;
        frame_end  = 1'b0;
        finish     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    start_scan = 1'b1;
                    state_d    = StRun;
                end
            end
            StRun: begin
                if (count_q == dwell_q) begin
                    capture = 1'b1;
                    if (sel_q == swidth'(3)) begin
                        frame_end = 1'b1;
                        // The stop latch is checked before this edge's stop is folded in.
                        if (!cont_q || stop_q) begin
                            finish  = 1'b1;
                            state_d = StIdle;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            dwell_q       <= '0;
            count_q       <= '0;
            cont_q        <= 1'b0;
            stop_q        <= 1'b0;
            sel_q         <= '0;
            cap_idx_q     <= '0;
            cap_data_q    <= '0;
            shadow_q[0]   <= '0;
            shadow_q[1]   <= '0;
            shadow_q[2]   <= '0;
            frame_data_q  <= '0;
            busy_q        <= 1'b0;
            cap_valid_q   <= 1'b0;
            frame_valid_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cap_valid_q   <= capture;
            frame_valid_q <= frame_end;
            done_q        <= finish;
            if (start_scan) begin
                dwell_q <= dwell;
                cont_q  <= continuous;
                sel_q   <= '0;
                count_q <= '0;
                busy_q  <= 1'b1;
                stop_q  <= 1'b0;
            end
            if (state_q == StRun) begin
                stop_q <= finish ? 1'b0 : (stop_q | stop);
                if (capture) begin
                    if (sel_q != swidth'(3)) begin
                        shadow_q[sel_q] <= mux_o;
                    end
                    cap_idx_q  <= sel_q;
                    cap_data_q <= mux_o;
                    count_q    <= '0;
                    sel_q      <= sel_q + swidth'(1);
                end else begin
                    count_q <= count_q + dwidth'(1);
                end
                if (frame_end) begin
                    frame_data_q <= {mux_o, shadow_q[2], shadow_q[1], shadow_q[0]};
                end
                if (finish) begin
                    busy_q <= 1'b0;
                    sel_q  <= '0;
                end
            end
        end
    end

    assign sel         = sel_q;
    assign busy        = busy_q;
    assign cap_valid   = cap_valid_q;
    assign cap_idx     = cap_idx_q;
    assign cap_data    = cap_data_q;
    assign frame_data  = frame_data_q;
    assign frame_valid = frame_valid_q;
    assign done        = done_q;

endmodule

// File: tb/tb_mux_scan_seq.sv
// Scoreboard bench for mux_scan_seq: stimulus predicts captures/frames from the
// dwell timing rules; a negedge monitor pops and compares whenever the DUT pulses.
module tb_mux_scan_seq;
    localparam int W  = 4;
    localparam int SW = 2;
    localparam int DW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, stop = 1'b0, continuous = 1'b0;
    logic [DW-1:0]  dwell = '0;
    logic [W-1:0]   in_ch [4];
    logic [W-1:0]   mux_o;
    logic [SW-1:0]  sel, cap_idx;
    logic           busy, cap_valid, frame_valid, done;
    logic [W-1:0]   cap_data;
    logic [4*W-1:0] frame_data;

    assign mux_o = in_ch[sel];

    mux_scan_seq #(.width(W), .swidth(SW), .dwidth(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .continuous(continuous),
        .dwell(dwell), .mux_o(mux_o), .sel(sel), .busy(busy), .cap_valid(cap_valid),
        .cap_idx(cap_idx), .cap_data(cap_data), .frame_data(frame_data),
        .frame_valid(frame_valid), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int edge_n; logic [1:0] idx; logic [W-1:0] data;} cap_t;
    typedef struct {int edge_n; logic [4*W-1:0] data; bit last;} frm_t;
    cap_t cap_q[$];
    frm_t frm_q[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor
    cap_t mc;
    frm_t mf;
    always @(negedge clk) begin
        if (rst_n) begin
            if (cap_valid) begin
                if (cap_q.size() == 0) check("cap_unexpected", 1, 0);
                else begin
                    mc = cap_q.pop_front();
                    check("cap_edge", cyc, mc.edge_n);
                    check("cap_idx", cap_idx, mc.idx);
                    check("cap_data", cap_data, mc.data);
                end
            end
            if (frame_valid) begin
                if (frm_q.size() == 0) check("frame_unexpected", 1, 0);
                else begin
                    mf = frm_q.pop_front();
                    check("frame_edge", cyc, mf.edge_n);
                    check("frame_data", frame_data, mf.data);
                    check("done", done, mf.last);
                    if (mf.last) begin
                        check("busy_end", busy, 0);
                        check("sel_end", sel, 0);
                    end
                end
            end else if (done) begin
                check("done_unexpected", 1, 0);
            end
        end
    end

    // One scan: single-shot, or continuous ending at the first frame end after stop at rel s.
    task automatic scan(input int d, input bit c, input int s, input bit chg, input bit noise,
                        input int cr);
        int e0, cur, rel, endf, n, k, hold;
        logic [4*W-1:0] acc;
        bit fin;
        hold = d + 1;
        endf = c ? (s / (4 * hold) + 1) : 1;
        acc  = '0;
        @(negedge clk);
        start      = 1'b1;
        dwell      = DW'(d);
        continuous = c;
        stop       = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        e0  = cyc + 1;
        fin = 1'b0;
        while (!fin) begin
            @(negedge clk);
            start = 1'b0;
            stop  = 1'b0;
            cur = cyc + 1;
            rel = cur - e0;
            check("busy_run", busy, 1);
            if (noise && $urandom_range(0, 3) == 0) start = 1'b1;
            if (c && rel == s) stop = 1'b1;
            if (!c && noise && $urandom_range(0, 3) == 0) stop = 1'b1;
            if (chg && $urandom_range(0, 1) == 1) in_ch[$urandom_range(0, 3)] = W'($urandom);
            if (rel == cr) in_ch[1] = 4'hE;
            if (rel % hold == 0) begin
                n = rel / hold - 1;
                k = n % 4;
                cap_q.push_back('{cur, 2'(k), in_ch[k]});
                acc[k*W +: W] = in_ch[k];
                if (k == 3) begin
                    fin = ((n / 4 + 1) == endf);
                    frm_q.push_back('{cur, acc, fin});
                end
            end
        end
        if (noise) begin
            @(negedge clk);
            start = 1'b0;
            stop  = 1'b1;
            @(negedge clk);
            stop  = 1'b0;
            check("busy_idle", busy, 0);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_sel"}, sel, 0);
        check({tag, "_cap"}, {cap_valid, cap_idx, cap_data}, 0);
        check({tag, "_frame"}, {frame_valid, frame_data}, 0);
        check({tag, "_done"}, done, 0);
    endtask

    task automatic reset_mid_frame();
        int e0, cur;
        @(negedge clk);
        start = 1'b1; dwell = '0; continuous = 1'b0; stop = 1'b0;
        e0 = cyc + 1;
        for (int r = 1; r <= 3; r++) begin
            @(negedge clk);
            start = 1'b0;
            cur = cyc + 1;
            cap_q.push_back('{cur, 2'(r - 1), in_ch[r - 1]});
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero("rst_mid");
        @(negedge clk);
        @(negedge clk);
        check("rst_no_frame", frame_valid, 0);
        rst_n = 1'b1;
        check("rst_queues", cap_q.size() + frm_q.size(), 0);
        if (e0 < 0) $display("unreachable");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        in_ch[0] = 4'hA; in_ch[1] = 4'hB; in_ch[2] = 4'hC; in_ch[3] = 4'hD;
        #1 check_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        scan(0, 1'b0, 0, 1'b0, 1'b0, -1);
        scan(2, 1'b0, 0, 1'b0, 1'b0, -1);
        scan(0, 1'b1, 5, 1'b0, 1'b0, -1);
        scan(0, 1'b0, 0, 1'b0, 1'b1, -1);
        scan(3, 1'b0, 0, 1'b0, 1'b0, 6);
        in_ch[1] = 4'hB;
        reset_mid_frame();
        scan(0, 1'b0, 0, 1'b0, 1'b0, -1);
        scan(1, 1'b1, 8, 1'b0, 1'b0, -1);
        for (int i = 0; i < 40; i++) begin
            int d;
            d = $urandom_range(0, 4);
            scan(d, 1'($urandom_range(0, 1)), $urandom_range(1, 12 * (d + 1)), 1'b1, 1'b1, -1);
        end
        repeat (3) @(negedge clk);
        check("leftover_caps", cap_q.size(), 0);
        check("leftover_frames", frm_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mux_scan_seq.md
Name: mux_scan_seq

Overview:
- Scan sequencer that drives the select of the team's 4:1 `width`-bit mux (`mux_if`) and samples the mux output on each channel.
- Steps `sel` through 0..3, holding each channel for a programmable dwell, and captures `o` into per-slot registers.
- Presents one complete 4-slot frame at a time, in single-shot or continuous mode.
- Sits around the mux: `sel` feeds the mux, `mux_o` is the mux's `o`.

Parameters:
- `width`, 4, data width of the mux channels and of each captured slot.
- `swidth`, 2, select width; fixed at 2 for 4 channels.
- `dwidth`, 4, width of the dwell count.

Ports:
- `clk`  input  1  system clock, rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `start`  input  1  begin a scan; sampled only in IDLE.
- `stop`  input  1  end continuous scanning at the next frame boundary; sampled only while busy.
- `continuous`  input  1  mode; latched at start (1 = repeat frames).
- `dwell`  input  `dwidth`  channel hold length minus one; latched at start.
- `mux_o`  input  `width`  mux output for the current `sel`.
- `sel`  output  `swidth`  select to the mux.
- `busy`  output  1  scan in progress.
- `cap_valid`  output  1  one-cycle pulse, a slot was captured.
- `cap_idx`  output  `swidth`  slot index of the last capture.
- `cap_data`  output  `width`  value of the last capture.
- `frame_data`  output  4*`width`  last complete frame; slot k at [k*`width` +: `width`].
- `frame_valid`  output  1  one-cycle pulse, `frame_data` updated.
- `done`  output  1  one-cycle pulse, scan ended, returned to IDLE.

Behaviour:
- Reset (async, `rst_n`=0): state IDLE; all outputs 0, including `frame_data`; dwell counter, shadow slots and stop latch cleared. Reset mid-frame aborts the frame with no `frame_valid` and no `done`.
- States are IDLE and RUN.
- IDLE -> RUN on the edge where `start`=1. At that edge: latch `dwell` into D and `continuous` into C; `sel`<=0; count<=0; `busy`<=1.
- RUN, each edge:
  - If count != D: count<=count+1.
  - If count == D: shadow[`sel`]<=`mux_o`; `cap_valid`<=1; `cap_idx`<=`sel`; `cap_data`<=`mux_o`; count<=0; `sel`<=`sel`+1, wrapping 3 -> 0.
- Channel hold is D+1 cycles; one frame is 4*(D+1) cycles.
- `mux_o` is sampled combinationally with `sel` stable for at least 1 cycle before sampling. `dwell`=0 is legal: one cycle per channel.
- Frame end is the capture of slot 3. On that edge:
  - `frame_data`<=shadow slots 0..2 plus `mux_o` as slot 3.
  - `frame_valid`<=1.
- After frame end, if C=0 or the stop latch is set: `done`<=1, `busy`<=0, `sel`<=0, stop latch cleared, go to IDLE. Otherwise continue RUN from slot 0 with no gap cycle.
- `stop` while busy sets the stop latch; it never truncates the current frame.
- `stop` in IDLE is ignored. `start` while busy is ignored.
- `start` and `stop` together in IDLE: the scan starts and `stop` is ignored.
- `stop` on the frame-end edge: it is latched and ends the following frame.
- `frame_data` holds its value between `frame_valid` pulses and through IDLE.
- `cap_valid`, `frame_valid` and `done` are single-cycle pulses and are otherwise 0.
- The next `start` is accepted in the cycle after `done`.

Test Plan:
- Single-shot, `dwell`=0, mux inputs i0..i3 = A,B,C,D, `start` at edge 0 -> `sel` 0,1,2,3 on cycles 1..4; `cap_valid` after edges 1..4 with `cap_idx` 0..3 and data A..D; after edge 4: `frame_data`=16'hDCBA, `frame_valid`=1, `done`=1, `busy`=0.
- `dwell`=2, single-shot -> each `sel` held 3 cycles; `frame_valid` and `done` 12 cycles after `start`; `frame_data`=16'hDCBA.
- Continuous, `dwell`=0, `stop` pulsed at cycle 5 -> frames complete at edges 4 and 8; `done` only at edge 8; `busy` low after edge 8.
- `start` pulsed at cycle 2 of a running scan, and `stop` pulsed in IDLE -> no effect on timing or data; `done` still after edge 4.
- `rst_n` low at cycle 3 of a `dwell`=0 frame -> all outputs 0 immediately; no `frame_valid`; a fresh `start` yields a full frame 4 cycles later.
- Inputs change mid-dwell (`dwell`=3, i1 changes B->E at cycle 6) -> slot 1 captures E, since sampling happens on the last dwell cycle.
